// File: rtl/fetch_pc_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_pc_ctrl_if
//  Description : Bundle of redirect requests, prediction inputs and fetch
//                outputs exchanged between the front-end and fetch_pc_ctrl.
//  Revision    : 1.0 - initial release
// ============================================================================
interface fetch_pc_ctrl_if #(
  parameter int XLEN = 32
);
  logic            stall_in;
  logic            rob_valid;
  logic            br_valid;
  logic            d1_valid;
  logic            ras_valid;
  logic [XLEN-1:0] rob_target;
  logic [XLEN-1:0] br_target;
  logic [XLEN-1:0] d1_target;
  logic [XLEN-1:0] ras_target;
  logic            bp_taken;
  logic [XLEN-1:0] bp_target;
  logic [XLEN-1:0] fetch_pc;
  logic            fetch_valid;
  logic            flush_out;
  logic [1:0]      redirect_src;
  logic [15:0]     redirect_cnt;

  // Requesters / pipeline environment side
  modport master (
    output stall_in, rob_valid, br_valid, d1_valid, ras_valid,
           rob_target, br_target, d1_target, ras_target, bp_taken, bp_target,
    input  fetch_pc, fetch_valid, flush_out, redirect_src, redirect_cnt
  );

  // PC controller side
  modport slave (
    input  stall_in, rob_valid, br_valid, d1_valid, ras_valid,
           rob_target, br_target, d1_target, ras_target, bp_taken, bp_target,
    output fetch_pc, fetch_valid, flush_out, redirect_src, redirect_cnt
  );
endinterface
`default_nettype wire

// File: rtl/fetch_pc_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_pc_ctrl
//  Description : Fetch PC generator. Arbitrates ROB/BR/D1/RAS redirects and
//                the branch predictor, parks a redirect while stalled, and
//                inserts one bubble after every applied redirect.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_pc_ctrl #(
  parameter int              XLEN        = 32,
  parameter int              FETCH_BYTES = 32,
  parameter logic [XLEN-1:0] RESET_PC    = '0
) (
  input  logic           clk,
  input  logic           rst,
  fetch_pc_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_HOLD  = 2'd1,
    S_FLUSH = 2'd2
  } state_t;

  state_t          state;
  logic [XLEN-1:0] cur_pc;
  logic            issue_valid;
  logic            flush_pulse;
  logic [1:0]      last_src;
  logic [15:0]     applied_cnt;
  logic            pend_valid;
  logic [1:0]      pend_src;
  logic [XLEN-1:0] pend_tgt;

  logic            req_any;
  logic [1:0]      req_src;
  logic [XLEN-1:0] req_tgt;
  logic            take_req;
  logic [1:0]      apply_src;
  logic [XLEN-1:0] apply_tgt;

  // Fixed-priority pick among this cycle's requests; a lower code wins.
  always_comb begin
    req_any = bus.rob_valid | bus.br_valid | bus.d1_valid | bus.ras_valid;
    req_src = 2'd3;
    req_tgt = bus.ras_target;
    if (bus.rob_valid) begin
      req_src = 2'd0;
      req_tgt = bus.rob_target;
    end else if (bus.br_valid) begin
      req_src = 2'd1;
      req_tgt = bus.br_target;
    end else if (bus.d1_valid) begin
      req_src = 2'd2;
      req_tgt = bus.d1_target;
    end
  end

  // A live request beats the parked one only at equal-or-higher priority.
  // Pending is only ever valid in HOLD, so outside HOLD this is just req_any.
  always_comb begin
    take_req  = req_any & (~pend_valid | (req_src <= pend_src));
    apply_src = take_req ? req_src : pend_src;
    apply_tgt = take_req ? req_tgt : pend_tgt;
  end

  // Control FSM with registered outputs; stalls only ever park or freeze.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_FLUSH;
      cur_pc      <= RESET_PC;
      issue_valid <= 1'b0;
      flush_pulse <= 1'b0;
      last_src    <= 2'd0;
      applied_cnt <= 16'd0;
      pend_valid  <= 1'b0;
      pend_src    <= 2'd0;
      pend_tgt    <= '0;
    end else begin
      // Any request, even one that only gets parked, kills in-flight fetches.
      flush_pulse <= req_any;
      if (bus.stall_in) begin
        if (req_any) begin
          state       <= S_HOLD;
          issue_valid <= 1'b0;
          if (take_req) begin
            pend_valid <= 1'b1;
            pend_src   <= req_src;
            pend_tgt   <= req_tgt;
          end
        end
      end else if (req_any || pend_valid) begin
        cur_pc      <= apply_tgt;
        last_src    <= apply_src;
        state       <= S_FLUSH;
        issue_valid <= 1'b0;
        pend_valid  <= 1'b0;
        if (applied_cnt != 16'hFFFF) begin
          applied_cnt <= applied_cnt + 16'd1;
        end
      end else begin
        case (state)
          S_FLUSH: begin
            state       <= S_RUN;
            issue_valid <= 1'b1;
          end
          S_RUN: begin
            cur_pc      <= bus.bp_taken ? bus.bp_target
                                        : cur_pc + XLEN'(FETCH_BYTES);
            issue_valid <= 1'b1;
          end
          default: begin
            // HOLD without a pending redirect cannot occur; recover to RUN.
            state       <= S_RUN;
            issue_valid <= 1'b1;
          end
        endcase
      end
    end
  end

  assign bus.fetch_pc     = cur_pc;
  assign bus.fetch_valid  = issue_valid;
  assign bus.flush_out    = flush_pulse;
  assign bus.redirect_src = last_src;
  assign bus.redirect_cnt = applied_cnt;

endmodule
`default_nettype wire

// File: tb/tb_fetch_pc_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_pc_ctrl
//  Description : Scoreboard bench for fetch_pc_ctrl: directed scenarios plus
//                random traffic against a rule-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_pc_ctrl;

  localparam logic [31:0] RST_PC = 32'h100;
  localparam int          FB     = 32;

  typedef struct {
    logic [31:0] pc;
    logic        valid;
    logic        flush;
    logic [1:0]  src;
    logic [15:0] cnt;
  } exp_t;

  logic clk;
  logic rst;
  fetch_pc_ctrl_if #(.XLEN(32)) bus ();

  fetch_pc_ctrl #(.XLEN(32), .FETCH_BYTES(FB), .RESET_PC(RST_PC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  exp_t sb_q[$];

  // Reference model state: pending index -1 means nothing parked (not HOLD).
  logic [31:0] m_pc;
  logic        m_valid;
  logic        m_bubble;
  int          m_pend;
  logic [31:0] m_ptgt;
  int          m_src;
  int          m_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, act, exp);
    end
  endtask

  // Apply one cycle of stimulus at the negedge, predict its outcome, queue it.
  task automatic step(input bit r, input bit st, input bit [3:0] v,
                      input logic [31:0] t0, input logic [31:0] t1,
                      input logic [31:0] t2, input logic [31:0] t3,
                      input bit bp, input logic [31:0] bpt);
    logic [31:0] t[4];
    int   win;
    int   sel;
    logic [31:0] stgt;
    exp_t e;
    t[0] = t0; t[1] = t1; t[2] = t2; t[3] = t3;
    rst = r;
    bus.stall_in  = st;
    bus.rob_valid = v[0]; bus.rob_target = t0;
    bus.br_valid  = v[1]; bus.br_target  = t1;
    bus.d1_valid  = v[2]; bus.d1_target  = t2;
    bus.ras_valid = v[3]; bus.ras_target = t3;
    bus.bp_taken  = bp;   bus.bp_target  = bpt;

    win = -1;
    for (int i = 0; i < 4; i++) if (v[i] && win < 0) win = i;
    e.flush = 1'b0;
    if (r) begin
      m_pc = RST_PC; m_valid = 0; m_bubble = 1; m_pend = -1; m_src = 0; m_cnt = 0;
    end else begin
      e.flush = (win >= 0);
      if (st) begin
        if (win >= 0) begin
          if (m_pend < 0 || win <= m_pend) begin
            m_pend = win;
            m_ptgt = t[win];
          end
          m_valid = 0;
        end
      end else begin
        sel = m_pend;
        stgt = m_ptgt;
        if (win >= 0 && (sel < 0 || win <= sel)) begin
          sel = win;
          stgt = t[win];
        end
        if (sel >= 0) begin
          m_pc = stgt; m_src = sel; m_valid = 0; m_bubble = 1; m_pend = -1;
          if (m_cnt < 65535) m_cnt++;
        end else if (m_bubble) begin
          m_bubble = 0; m_valid = 1;
        end else begin
          m_pc = bp ? bpt : m_pc + FB;
          m_valid = 1;
        end
      end
    end
    e.pc = m_pc; e.valid = m_valid; e.src = 2'(m_src); e.cnt = 16'(m_cnt);
    sb_q.push_back(e);
    @(negedge clk);
    cyc++;
  endtask

  task automatic idle(input bit st);
    step(1'b0, st, 4'b0000, '0, '0, '0, '0, 1'b0, '0);
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 4'b0000, '0, '0, '0, '0, 1'b0, '0);
  endtask

  // Monitor: the DUT presents a result every cycle; compare it just after the edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk("sb_pc",    bus.fetch_pc,            e.pc);
      chk("sb_valid", 32'(bus.fetch_valid),    32'(e.valid));
      chk("sb_flush", 32'(bus.flush_out),      32'(e.flush));
      chk("sb_src",   32'(bus.redirect_src),   32'(e.src));
      chk("sb_cnt",   32'(bus.redirect_cnt),   32'(e.cnt));
    end
  end

  int pulses;

  // Stimulus: directed scenarios with constant expectations, then random traffic.
  initial begin
    rst = 1'b1;
    bus.stall_in = 0; bus.bp_taken = 0; bus.bp_target = '0;
    bus.rob_valid = 0; bus.br_valid = 0; bus.d1_valid = 0; bus.ras_valid = 0;
    bus.rob_target = '0; bus.br_target = '0; bus.d1_target = '0; bus.ras_target = '0;
    @(negedge clk);

    // Reset then sequential fetch
    do_reset();
    chk("rst_valid", 32'(bus.fetch_valid), 32'd0);
    chk("rst_pc", bus.fetch_pc, 32'h100);
    chk("rst_cnt", 32'(bus.redirect_cnt), 32'd0);
    idle(0);
    chk("seq0_valid", 32'(bus.fetch_valid), 32'd1);
    chk("seq0_pc", bus.fetch_pc, 32'h100);
    idle(0);
    chk("seq1_pc", bus.fetch_pc, 32'h120);
    idle(0);
    chk("seq2_pc", bus.fetch_pc, 32'h140);

    // ROB beats BR in the same cycle
    do_reset(); idle(0);
    step(0, 0, 4'b0011, 32'h4000, 32'h8000, '0, '0, 0, '0);
    chk("prio_pc", bus.fetch_pc, 32'h4000);
    chk("prio_src", 32'(bus.redirect_src), 32'd0);
    chk("prio_flush", 32'(bus.flush_out), 32'd1);
    chk("prio_cnt", 32'(bus.redirect_cnt), 32'd1);
    chk("prio_valid", 32'(bus.fetch_valid), 32'd0);
    idle(0);
    chk("prio_valid2", 32'(bus.fetch_valid), 32'd1);
    chk("prio_flush2", 32'(bus.flush_out), 32'd0);

    // Stalled requests: RAS parked, D1 overwrites, later RAS dropped
    do_reset(); idle(0);
    pulses = 0;
    step(0, 1, 4'b1000, '0, '0, '0, 32'h200, 0, '0); pulses += int'(bus.flush_out);
    step(0, 1, 4'b0100, '0, '0, 32'h300, '0, 0, '0); pulses += int'(bus.flush_out);
    step(0, 1, 4'b1000, '0, '0, '0, 32'h500, 0, '0); pulses += int'(bus.flush_out);
    chk("hold_pc", bus.fetch_pc, 32'h100);
    chk("hold_valid", 32'(bus.fetch_valid), 32'd0);
    idle(0); pulses += int'(bus.flush_out);
    chk("hold_rel_pc", bus.fetch_pc, 32'h300);
    chk("hold_rel_src", 32'(bus.redirect_src), 32'd2);
    chk("hold_rel_cnt", 32'(bus.redirect_cnt), 32'd1);
    chk("hold_pulses", 32'(pulses), 32'd3);

    // Predictor taken in RUN, ignored during FLUSH
    do_reset(); idle(0);
    step(0, 0, 4'b0001, 32'h1000, '0, '0, '0, 0, '0);
    idle(0);
    chk("bp_start_pc", bus.fetch_pc, 32'h1000);
    step(0, 0, 4'b0000, '0, '0, '0, '0, 1, 32'h2000);
    chk("bp_pc", bus.fetch_pc, 32'h2000);
    chk("bp_flush", 32'(bus.flush_out), 32'd0);
    chk("bp_valid", 32'(bus.fetch_valid), 32'd1);
    step(0, 0, 4'b0001, 32'h3000, '0, '0, '0, 0, '0);
    step(0, 0, 4'b0000, '0, '0, '0, '0, 1, 32'h9000);
    chk("bp_flush_ign_pc", bus.fetch_pc, 32'h3000);
    chk("bp_flush_ign_valid", 32'(bus.fetch_valid), 32'd1);

    // PC wrap at the top of the address space
    step(0, 0, 4'b0001, 32'hFFFF_FFE0, '0, '0, '0, 0, '0);
    idle(0);
    chk("wrap_pre", bus.fetch_pc, 32'hFFFF_FFE0);
    idle(0);
    chk("wrap_pc", bus.fetch_pc, 32'h0);

    // Reset during HOLD discards the parked redirect
    do_reset(); idle(0);
    step(0, 1, 4'b0001, 32'h700, '0, '0, '0, 0, '0);
    step(1, 1, 4'b0001, 32'h700, '0, '0, '0, 0, '0);
    chk("rsthold_pc", bus.fetch_pc, 32'h100);
    chk("rsthold_cnt", 32'(bus.redirect_cnt), 32'd0);
    idle(0);
    chk("rsthold_pc2", bus.fetch_pc, 32'h100);
    chk("rsthold_valid2", 32'(bus.fetch_valid), 32'd1);
    idle(0);
    chk("rsthold_pc3", bus.fetch_pc, 32'h120);
    chk("rsthold_cnt3", 32'(bus.redirect_cnt), 32'd0);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      bit [3:0] v;
      for (int i = 0; i < 4; i++) v[i] = ($urandom_range(0, 7) == 0);
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 2) == 0), v,
           $urandom, $urandom, $urandom, $urandom,
           ($urandom_range(0, 2) == 0), $urandom);
    end

    idle(0);
    @(negedge clk);
    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
